// File: rtl/block_read_spi_if.sv
// SPI-side signal bundle of block_read_spi: external master pins plus the parallel word read out.
// Framing contract: the master pulls cs low, clocks 8 address bits then Nbit data bits in mode 0 and raises cs to end the frame.
interface block_read_spi_if #(
   parameter int Nbit = 32
);
   logic            sclk;
   logic            mosi;
   logic            miso;
   logic            cs;
   logic [Nbit-1:0] inport;

   modport master (
      output sclk,
      output mosi,
      output cs,
      output inport,
      input  miso
   );

   modport slave (
      input  sclk,
      input  mosi,
      input  cs,
      input  inport,
      output miso
   );
endinterface

// File: rtl/block_read_spi.sv
// SPI mode-0 slave read port, oversampled on clk: an 8-bit address is matched against param_adr,
// and on a hit the inport word is snapshotted and shifted out on miso, MSB first.
module block_read_spi #(
   parameter int         Nbit      = 32,
   parameter logic [7:0] param_adr = 8'd1
) (
   input  logic                clk,
   input  logic                rst,
   block_read_spi_if.slave     bus,
   output logic [2:0]          o_state
);

   localparam int CW = ($clog2(Nbit + 1) > 4) ? $clog2(Nbit + 1) : 4;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
      S_SKIP = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Synchronizers; sclk has a third stage so edges are seen exactly once.
   logic [2:0]      r_sclk_sync;
   logic [1:0]      r_mosi_sync;
   logic [1:0]      r_cs_sync;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [7:0]      r_adr;
   logic [Nbit-1:0] r_shift;
   logic            r_miso;

   state_t          w_state_nxt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [7:0]      w_adr_nxt;
   logic [Nbit-1:0] w_shift_nxt;
   logic            w_miso_nxt;

   logic            w_sclk_rise;
   logic            w_sclk_fall;
   logic            w_cs_high;
   logic [7:0]      w_adr_shifted;
   logic [Nbit-1:0] w_shift_step;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sclk_sync <= 3'b000;
         r_mosi_sync <= 2'b00;
         r_cs_sync   <= 2'b11;
      end else begin
         r_sclk_sync <= {r_sclk_sync[1:0], bus.sclk};
         r_mosi_sync <= {r_mosi_sync[0], bus.mosi};
         r_cs_sync   <= {r_cs_sync[0], bus.cs};
      end
   end

   assign w_sclk_rise   = r_sclk_sync[1] & ~r_sclk_sync[2];
   assign w_sclk_fall   = ~r_sclk_sync[1] & r_sclk_sync[2];
   assign w_cs_high     = r_cs_sync[1];
   assign w_adr_shifted = {r_adr[6:0], r_mosi_sync[1]};

   // The first data fall presents the snapshot MSB unshifted; later falls shift first.
   assign w_shift_step  = (r_cnt == '0) ? r_shift : {r_shift[Nbit-2:0], 1'b0};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_adr   <= '0;
         r_shift <= '0;
         r_miso  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_adr   <= w_adr_nxt;
         r_shift <= w_shift_nxt;
         r_miso  <= w_miso_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_adr_nxt   = r_adr;
      w_shift_nxt = r_shift;
      w_miso_nxt  = 1'b0;

      if (w_cs_high) begin
         // cs high overrides any sclk edge seen in the same cycle.
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         w_adr_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
               if (w_sclk_rise) begin
                  w_adr_nxt = w_adr_shifted;
                  if (r_cnt == CW'(7)) begin
                     w_cnt_nxt = '0;
                     if (w_adr_shifted == param_adr) begin
                        w_shift_nxt = bus.inport;
                        w_state_nxt = S_DATA;
                     end else begin
                        w_state_nxt = S_SKIP;
                     end
                  end else begin
                     w_cnt_nxt = r_cnt + CW'(1);
                  end
               end
            end
            S_DATA: begin
               w_miso_nxt = r_miso;
               if (w_sclk_fall) begin
                  if (r_cnt == CW'(Nbit)) begin
                     w_miso_nxt  = 1'b0;
                     w_state_nxt = S_DONE;
                  end else begin
                     w_shift_nxt = w_shift_step;
                     w_miso_nxt  = w_shift_step[Nbit-1];
                     w_cnt_nxt   = r_cnt + CW'(1);
                  end
               end
            end
            S_SKIP, S_DONE: begin
               w_miso_nxt = 1'b0;
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign bus.miso = r_miso;
   assign o_state  = r_state;

endmodule

// File: tb/tb_block_read_spi.sv
// Directed bench for block_read_spi: a vector table of full frames plus hand-written
// sequences for reset, aborted frames and stray sclk activity.
module tb_block_read_spi;

   localparam int NBIT = 32;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_SKIP = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] dbg_state;

   always #5 clk = ~clk;

   block_read_spi_if #(.Nbit(NBIT)) bus ();

   block_read_spi #(
      .Nbit      (NBIT),
      .param_adr (8'd1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .o_state (dbg_state)
   );

   typedef struct {
      logic [7:0]  adr;
      logic [31:0] inport;
      logic        chg;
      logic [31:0] new_inport;
      logic [31:0] exp_rd;
      logic [2:0]  exp_state;
   } vec_t;

   vec_t        vecs[8];
   logic [31:0] exp_q[$];
   int          total = 0;
   int          bad   = 0;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One sclk period: mosi set while low, miso sampled just before the rising edge.
   task automatic spi_bit(input logic b, output logic s);
      bus.mosi = b;
      tick(5);
      s = bus.miso;
      bus.sclk = 1'b1;
      tick(5);
      bus.sclk = 1'b0;
   endtask

   task automatic send_adr(input logic [7:0] a, output logic any_hi);
      logic s;
      any_hi = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(a[i], s);
         any_hi = any_hi | s;
      end
   endtask

   task automatic read_bits(input int n, output logic [31:0] rd);
      logic s;
      rd = '0;
      for (int i = 0; i < n; i++) begin
         spi_bit(1'b0, s);
         rd = {rd[30:0], s};
      end
   endtask

   task automatic run_frame(input vec_t v);
      logic        any_hi;
      logic [31:0] rd;
      bus.inport = v.inport;
      bus.cs     = 1'b0;
      tick(4);
      send_adr(v.adr, any_hi);
      check("adr_phase_miso", {31'd0, any_hi}, 32'd0);
      if (v.chg) bus.inport = v.new_inport;
      exp_q.push_back(v.exp_rd);
      read_bits(32, rd);
      check("read_data", rd, exp_q.pop_front());
      tick(6);
      check("post_frame_miso", {31'd0, bus.miso}, 32'd0);
      check("post_frame_state", {29'd0, dbg_state}, {29'd0, v.exp_state});
      bus.cs = 1'b1;
      tick(4);
      check("cs_high_miso", {31'd0, bus.miso}, 32'd0);
      check("cs_high_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
   endtask

   initial begin
      logic        s;
      logic        any_hi;
      logic [31:0] rd;

      vecs[0] = '{8'h01, 32'hDEEDBEEF, 1'b0, 32'h0,        32'hDEEDBEEF, ST_DONE};
      vecs[1] = '{8'h01, 32'h00000044, 1'b1, 32'hFFFFFFFF, 32'h00000044, ST_DONE};
      vecs[2] = '{8'h03, 32'h00000044, 1'b0, 32'h0,        32'h00000000, ST_SKIP};
      vecs[3] = '{8'h01, 32'h00000045, 1'b0, 32'h0,        32'h00000045, ST_DONE};
      vecs[4] = '{8'h00, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h00000000, ST_SKIP};
      vecs[5] = '{8'h81, 32'h80000001, 1'b0, 32'h0,        32'h00000000, ST_SKIP};
      vecs[6] = '{8'h01, 32'h80000001, 1'b0, 32'h0,        32'h80000001, ST_DONE};
      vecs[7] = '{8'hFF, 32'h12345678, 1'b0, 32'h0,        32'h00000000, ST_SKIP};

      rst        = 1'b0;
      bus.sclk   = 1'b0;
      bus.mosi   = 1'b0;
      bus.cs     = 1'b1;
      bus.inport = '0;
      tick(10);
      check("reset_miso", {31'd0, bus.miso}, 32'd0);
      check("reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
      rst = 1'b1;
      tick(5);
      check("post_reset_miso", {31'd0, bus.miso}, 32'd0);
      check("post_reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});

      for (int i = 0; i < 8; i++) run_frame(vecs[i]);

      // Asynchronous reset in the middle of the data phase.
      bus.inport = 32'hFFFFFFFF;
      bus.cs     = 1'b0;
      tick(4);
      send_adr(8'h01, any_hi);
      read_bits(4, rd);
      check("pre_reset_bits", rd, 32'h0000000F);
      tick(4);
      check("pre_reset_miso", {31'd0, bus.miso}, 32'd1);
      rst = 1'b0;
      #1;
      check("mid_data_reset_miso", {31'd0, bus.miso}, 32'd0);
      check("mid_data_reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
      bus.cs = 1'b1;
      tick(3);
      rst = 1'b1;
      tick(4);
      run_frame('{8'h01, 32'hCAFE0001, 1'b0, 32'h0, 32'hCAFE0001, ST_DONE});

      // cs raised after four address bits; the next frame must be aligned.
      bus.cs = 1'b0;
      tick(4);
      for (int i = 0; i < 4; i++) spi_bit(1'b1, s);
      bus.cs = 1'b1;
      tick(4);
      check("abort_adr_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
      run_frame('{8'h01, 32'hA5A50F0F, 1'b0, 32'h0, 32'hA5A50F0F, ST_DONE});

      // cs raised in the middle of the data phase while miso is high.
      bus.inport = 32'hFFFFFFFF;
      bus.cs     = 1'b0;
      tick(4);
      send_adr(8'h01, any_hi);
      read_bits(8, rd);
      check("partial_bits", rd, 32'h000000FF);
      tick(4);
      check("partial_miso_hi", {31'd0, bus.miso}, 32'd1);
      bus.cs = 1'b1;
      tick(4);
      check("abort_data_miso", {31'd0, bus.miso}, 32'd0);
      check("abort_data_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});

      // sclk activity with cs high is ignored.
      for (int i = 0; i < 8; i++) spi_bit(1'b1, s);
      check("stray_sclk_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
      check("stray_sclk_miso", {31'd0, bus.miso}, 32'd0);
      run_frame('{8'h01, 32'h0000_0001, 1'b0, 32'h0, 32'h0000_0001, ST_DONE});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
